// File: rtl/result_pager_pkg.sv
// Shared types and constants for the result pager: FSM encoding, page count
// and page-index width derived from the default word and LED widths.
package result_pager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } pager_state_t;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int LED_WIDTH_DEF  = 16;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PAGES  = DATA_WIDTH_DEF / LED_WIDTH_DEF;
    localparam int PAGE_W = idx_width(PAGES);

endpackage

// File: rtl/result_pager_if.sv
// Producer-side strobe bus plus the LED display outputs of the result pager.
interface result_pager_if
    import result_pager_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LED_WIDTH  = LED_WIDTH_DEF,
    parameter int PAGE_W     = result_pager_pkg::PAGE_W
);
    logic [DATA_WIDTH-1:0] result;
    logic                  resultValid;
    logic                  ready;
    logic [LED_WIDTH-1:0]  led;
    logic [PAGE_W-1:0]     pageIdx;
    logic                  overflow;

    modport master (
        output result, resultValid,
        input  ready, led, pageIdx, overflow
    );

    modport slave (
        input  result, resultValid,
        output ready, led, pageIdx, overflow
    );
endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO buffering captured results. A push while full is
// still accepted when a pop happens on the same edge.
module result_fifo
    import result_pager_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_dout  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_pager.sv
// Captures ALU results into a FIFO and pages each word across the LEDs,
// one LED-wide slice per page, LSB slice first, with a programmable dwell.
//
// state | meaning
// IDLE  | nothing shown yet, LEDs dark; leave as soon as a word is buffered
// LOAD  | pop FIFO head into the display word and show slice 0
// SHOW  | hold each page for the dwell; loop the word unless another is queued
module result_pager
    import result_pager_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int LED_WIDTH    = LED_WIDTH_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic          clk,
    input  logic          rst,
    result_pager_if.slave bus
);
    localparam int L_PAGES  = DATA_WIDTH / LED_WIDTH;
    localparam int L_PAGE_W = idx_width(L_PAGES);
    localparam int CNT_W    = idx_width(DWELL_CYCLES);
    localparam logic [L_PAGE_W-1:0] LAST_PAGE  = L_PAGE_W'(L_PAGES - 1);
    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    pager_state_t r_state;
    pager_state_t w_state_next;

    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_wrap;
    logic                  w_dwell_done;

    logic [DATA_WIDTH-1:0] r_word;
    logic [LED_WIDTH-1:0]  r_led;
    logic [L_PAGE_W-1:0]   r_page;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_overflow;
    logic [L_PAGE_W-1:0]   w_next_page;
    logic [LED_WIDTH-1:0]  w_slices [L_PAGES];

    result_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.resultValid),
        .i_pop   (w_pop),
        .i_din   (bus.result),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    for (genvar g = 0; g < L_PAGES; g++) begin : g_slice
        assign w_slices[g] = r_word[g*LED_WIDTH +: LED_WIDTH];
    end

    assign w_next_page  = r_page + L_PAGE_W'(1);
    assign w_dwell_done = (r_state == SHOW) && (r_cnt == DWELL_LAST);

    assign bus.ready    = ~w_full;
    assign bus.led      = r_led;
    assign bus.pageIdx  = r_page;
    assign bus.overflow = r_overflow;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle display controls.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_pop        = 1'b1;
                w_load       = 1'b1;
                w_state_next = SHOW;
            end
            SHOW: begin
                if (w_dwell_done) begin
                    if (r_page != LAST_PAGE) begin
                        w_advance = 1'b1;
                    end else if (!w_empty) begin
                        w_state_next = LOAD;
                    end else begin
                        w_wrap = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Display word, LED slice, page index and dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_led  <= '0;
            r_page <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_word <= w_fifo_dout;
            r_led  <= w_fifo_dout[LED_WIDTH-1:0];
            r_page <= '0;
            r_cnt  <= '0;
        end else if (r_state == SHOW) begin
            if (w_dwell_done) begin
                r_cnt <= '0;
                if (w_advance) begin
                    r_page <= w_next_page;
                    r_led  <= w_slices[w_next_page];
                end else if (w_wrap) begin
                    r_page <= '0;
                    r_led  <= w_slices[0];
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_led  <= '0;
            r_page <= '0;
            r_cnt  <= '0;
        end
    end

    // Sticky flag for a strobe lost to a full FIFO with no same-edge pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.resultValid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_pager.sv
module tb_result_pager;
    import result_pager_pkg::*;

    localparam int DW    = 64;
    localparam int LW    = 16;
    localparam int DWELL = 4;
    localparam int NP    = DW / LW;

    typedef struct {
        logic [DW-1:0] word;
        bit            accept;
        bit            exp_ready;
        bit            exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q [$];
    vec_t          tbl   [$];

    always #5 clk = ~clk;

    result_pager_if #(.DATA_WIDTH(DW), .LED_WIDTH(LW), .PAGE_W(PAGE_W)) bus ();

    result_pager #(
        .DATA_WIDTH   (DW),
        .LED_WIDTH    (LW),
        .FIFO_DEPTH   (4),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " led"},      64'(bus.led),      64'h0);
        chk({tag, " pageIdx"},  64'(bus.pageIdx),  64'h0);
        chk({tag, " ready"},    64'(bus.ready),    64'h1);
        chk({tag, " overflow"}, 64'(bus.overflow), 64'h0);
    endtask

    // Apply the strobe table on consecutive cycles; accepted words go to the scoreboard.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            bus.result      = tbl[i].word;
            bus.resultValid = 1'b1;
            if (tbl[i].accept) exp_q.push_back(tbl[i].word);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s ready[%0d]", tag, i),    64'(bus.ready),    64'(tbl[i].exp_ready));
            chk($sformatf("%s overflow[%0d]", tag, i), 64'(bus.overflow), 64'(tbl[i].exp_ovf));
        end
        bus.resultValid = 1'b0;
    endtask

    // Check every cycle of one full pass over a word; last page holds one extra
    // cycle when another word is waiting.
    task automatic show_pages(input logic [DW-1:0] w, input string tag);
        int hold;
        for (int p = 0; p < NP; p++) begin
            hold = (p == NP - 1 && exp_q.size() != 0) ? DWELL + 1 : DWELL;
            for (int c = 0; c < hold; c++) begin
                chk($sformatf("%s led p%0d c%0d", tag, p, c), 64'(bus.led), 64'(w[p*LW +: LW]));
                chk($sformatf("%s pageIdx p%0d c%0d", tag, p, c), 64'(bus.pageIdx), 64'(p));
                @(negedge clk);
            end
        end
    endtask

    task automatic check_next_word(input string tag, output logic [DW-1:0] w);
        w = '0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard: got empty queue, want a pending word", tag);
        end else begin
            w = exp_q.pop_front();
            show_pages(w, tag);
        end
    endtask

    // From IDLE: LEDs stay dark for two edges, then the scoreboard words play out.
    task automatic watch(input string tag, input int nwords);
        logic [DW-1:0] w;
        @(negedge clk);
        chk({tag, " latency1 led"}, 64'(bus.led), 64'h0);
        @(negedge clk);
        chk({tag, " latency2 led"}, 64'(bus.led), 64'h0);
        @(negedge clk);
        for (int k = 0; k < nwords; k++) begin
            check_next_word($sformatf("%s w%0d", tag, k), w);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_idle({tag, " async"});
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        bus.result      = '0;
        bus.resultValid = 1'b0;

        // Reset then idle.
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", i));
        end

        // Single word, then it loops.
        tbl = '{'{64'h0004_0003_0002_0001, 1'b1, 1'b1, 1'b0}};
        fork
            run_table("single");
            begin
                watch("single", 1);
                show_pages(64'h0004_0003_0002_0001, "loop");
            end
        join

        // Back-to-back words.
        do_reset("rst_b2b");
        tbl = '{'{64'h1111_1111_1111_1111, 1'b1, 1'b1, 1'b0},
                '{64'h2222_2222_2222_2222, 1'b1, 1'b1, 1'b0}};
        fork
            run_table("b2b");
            watch("b2b", 2);
        join
        chk("b2b overflow", 64'(bus.overflow), 64'h0);

        // Overflow: sixth strobe dropped, flag sticky until reset.
        do_reset("rst_ovf");
        tbl = '{'{64'hA104_A103_A102_A101, 1'b1, 1'b1, 1'b0},
                '{64'hA204_A203_A202_A201, 1'b1, 1'b1, 1'b0},
                '{64'hA304_A303_A302_A301, 1'b1, 1'b1, 1'b0},
                '{64'hA404_A403_A402_A401, 1'b1, 1'b1, 1'b0},
                '{64'hA504_A503_A502_A501, 1'b1, 1'b0, 1'b0},
                '{64'hA604_A603_A602_A601, 1'b0, 1'b0, 1'b1}};
        fork
            run_table("ovf");
            watch("ovf", 5);
        join
        repeat (10) @(negedge clk);
        chk("ovf sticky", 64'(bus.overflow), 64'h1);
        do_reset("rst_ovf_clear");
        @(negedge clk);
        chk("ovf cleared", 64'(bus.overflow), 64'h0);

        // Push coinciding with LOAD pop while full.
        do_reset("rst_pp");
        tbl = '{'{64'hB104_B103_B102_B101, 1'b1, 1'b1, 1'b0},
                '{64'hB204_B203_B202_B201, 1'b1, 1'b1, 1'b0},
                '{64'hB304_B303_B302_B301, 1'b1, 1'b1, 1'b0},
                '{64'hB404_B403_B402_B401, 1'b1, 1'b1, 1'b0},
                '{64'hB504_B503_B502_B501, 1'b1, 1'b0, 1'b0}};
        fork
            begin
                run_table("pp");
                repeat (14) @(negedge clk);
                chk("pp full before", 64'(bus.ready), 64'h0);
                bus.result      = 64'hB604_B603_B602_B601;
                bus.resultValid = 1'b1;
                exp_q.push_back(64'hB604_B603_B602_B601);
                @(posedge clk);
                @(negedge clk);
                chk("pp ready after", 64'(bus.ready), 64'h0);
                chk("pp overflow after", 64'(bus.overflow), 64'h0);
                bus.result = 64'hB704_B703_B702_B701;
                @(posedge clk);
                @(negedge clk);
                bus.resultValid = 1'b0;
                chk("pp still full drop", 64'(bus.overflow), 64'h1);
            end
            watch("pp", 6);
        join

        // Async reset in the middle of page 2.
        do_reset("rst_mid");
        tbl = '{'{64'hC004_C003_C002_C001, 1'b1, 1'b1, 1'b0},
                '{64'hD004_D003_D002_D001, 1'b1, 1'b1, 1'b0}};
        run_table("mid");
        repeat (10) @(negedge clk);
        chk("mid pageIdx", 64'(bus.pageIdx), 64'h2);
        chk("mid led", 64'(bus.led), 64'hC003);
        #2 rst = 1'b1;
        #1 chk_idle("mid async");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("mid flushed led%0d", i), 64'(bus.led), 64'h0);
        end
        tbl = '{'{64'hE004_E003_E002_E001, 1'b1, 1'b1, 1'b0}};
        fork
            run_table("fresh");
            watch("fresh", 1);
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_pager.md
Name: result_pager

Overview:
- Downstream consumer of the datapath's 64-bit ALU result.
- Captures each result on its store pulse into a small FIFO.
- Pages every captured word across the 16 board LEDs, four 16-bit slices at a time, with a programmable dwell per page.
- Lets a user read full 64-bit sums on the 16 LEDs and buffers results that arrive faster than they can be shown.

Parameters:
- DATA_WIDTH, 64, width of captured result word.
- LED_WIDTH, 16, LED count; DATA_WIDTH must be an integer multiple of LED_WIDTH.
- FIFO_DEPTH, 4, result buffer entries; must be a power of two, at least 2.
- DWELL_CYCLES, 100000000, clocks each page is displayed; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- result  in  DATA_WIDTH  word to capture.
- resultValid  in  1  single-cycle capture strobe, driven from the store-result control.
- ready  out  1  high when the FIFO is not full.
- led  out  LED_WIDTH  displayed slice; registered.
- pageIdx  out  log2(DATA_WIDTH/LED_WIDTH)  index of the slice currently on led.
- overflow  out  1  sticky; set when a strobe is dropped.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - led = 0, pageIdx = 0, overflow = 0, ready = 1.
  - FIFO empty; state IDLE; dwell counter = 0.
  - Reset mid-display discards all buffered and displayed data immediately.
- Capture:
  - On an edge with resultValid=1 and FIFO not full, result is pushed.
  - On an edge with resultValid=1 and FIFO full, the word is dropped and overflow is set to 1. overflow clears only on rst.
  - Push and pop on the same edge: both take effect and occupancy is unchanged. When full, a push that coincides with a pop is accepted and overflow does not set.
  - ready = not full, combinational from occupancy.
- FSM states: IDLE, LOAD, SHOW.
  - IDLE: led = 0. If the FIFO is not empty, go to LOAD.
  - LOAD: pop the FIFO head into the display register. At the same edge: led <= word[LED_WIDTH-1:0], pageIdx <= 0, counter <= 0, go to SHOW.
  - SHOW: the counter increments each cycle. When counter == DWELL_CYCLES-1:
    - counter <= 0.
    - If pageIdx is not the last page: pageIdx increments and led <= the next slice.
    - If pageIdx is the last page and the FIFO is not empty: go to LOAD; led holds the last slice.
    - If pageIdx is the last page and the FIFO is empty: pageIdx <= 0 and led <= slice 0. The current word loops indefinitely.
- Slice order: page p shows word[p*LED_WIDTH +: LED_WIDTH], so page 0 is the LSBs.
- Latency: a strobe sampled at edge E0 produces led = slice 0 after edge E2, when starting from IDLE with the FIFO empty.
- Dwell timing:
  - Each page is held exactly DWELL_CYCLES clocks.
  - The last page of a word followed by a buffered word is held DWELL_CYCLES+1 clocks, because of the LOAD cycle.
- With DWELL_CYCLES=1, pages advance every clock.
- The FSM never returns to IDLE except via rst.
- Width rules: all counters are unsigned. The dwell counter is wide enough for DWELL_CYCLES-1. The FIFO pointers wrap modulo FIFO_DEPTH, with a separate occupancy count of width log2(FIFO_DEPTH)+1.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, SHOW=2'd2);
  - the PAGES = DATA_WIDTH/LED_WIDTH constant;
  - the page index width.
- One sub-module, result_fifo: a synchronous FIFO with push, pop, dout, full, empty and an async active-high rst.
- The pager FSM, dwell counter and slice mux live in result_pager.

Test Plan:
- Reset then idle, DWELL_CYCLES=4: no strobes for 20 cycles -> led=0, pageIdx=0, ready=1, overflow=0 throughout.
- Single word 64'h0004_0003_0002_0001: one strobe -> led=16'h0001 after 2 edges. Then 16'h0002, 16'h0003, 16'h0004, each held exactly 4 cycles, then 16'h0001 again (loop).
- Back-to-back words A=64'h1111_..., B=64'h2222_...: strobes on consecutive cycles -> A pages shown fully, A's last page held 5 cycles, then B page 0 = 16'h2222. overflow stays 0.
- Overflow: 6 consecutive strobes while the first word is on display -> ready drops after the 5th (1 displayed, 4 buffered). The 6th word is dropped, overflow=1 and stays 1 until rst.
- Simultaneous push/pop: FIFO full, strobe coincides with the LOAD pop -> word accepted, occupancy unchanged, overflow stays 0.
- Async reset mid-SHOW on page 2: assert rst between edges -> led=0, pageIdx=0, FIFO empty immediately. After release, the next strobe displays a fresh word with the same 2-edge latency.
